// File: rtl/jtag_burst_sequencer.sv
// JTAG-side burst sequencer: drives the ping-pong buffer and launches DMA
// transfers for host write bursts and host read bursts.
module jtag_burst_sequencer (
    input  logic        JTCK,
    input  logic        JRSTN,
    input  logic        cmd_write_start,
    input  logic        cmd_read_start,
    input  logic        cmd_abort,
    input  logic [31:0] cfg_address,
    input  logic [3:0]  cfg_byte_enable,
    input  logic [7:0]  cfg_burst_size,
    input  logic        wr_data_valid,
    input  logic [31:0] wr_data,
    input  logic        rd_word_ack,
    input  logic        switch_ready,
    input  logic [31:0] pp_dataOut,
    output logic [8:0]  pp_address,
    output logic        pp_writeEnable,
    output logic [31:0] pp_dataIn,
    output logic        pp_switch,
    output logic [31:0] dma_address,
    output logic [3:0]  dma_byte_enable,
    output logic [7:0]  dma_burst_size,
    output logic        dma_data_ready,
    output logic        dma_readReady,
    output logic [31:0] rd_data,
    output logic [3:0]  status
);

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned STAT_W = 4;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        W_FILL    = 4'd1,
        W_WRITE   = 4'd2,
        W_WAIT_SW = 4'd3,
        W_SWITCH  = 4'd4,
        W_LAUNCH  = 4'd5,
        R_LAUNCH  = 4'd6,
        R_WAIT_SW = 4'd7,
        R_SWITCH  = 4'd8,
        R_ASK     = 4'd9,
        R_STORE   = 4'd10,
        R_HOLD    = 4'd11
    } state_t;

    state_t              state_q,    state_nxt;
    logic [IDX_W-1:0]    index_q,    index_nxt;
    logic [DATA_W-1:0]   data_q,     data_nxt;
    logic [DATA_W-1:0]   rd_data_nxt;
    logic [DATA_W-1:0]   cfg_addr_q, cfg_addr_nxt;
    logic [BE_W-1:0]     cfg_be_q,   cfg_be_nxt;
    logic [IDX_W-1:0]    cfg_bs_q,   cfg_bs_nxt;
    logic                err_q,      err_nxt;

    logic [ADDR_W-1:0]   pp_address_nxt;
    logic                pp_we_nxt;
    logic [DATA_W-1:0]   pp_din_nxt;
    logic                pp_switch_nxt;
    logic [DATA_W-1:0]   dma_addr_nxt;
    logic [BE_W-1:0]     dma_be_nxt;
    logic [IDX_W-1:0]    dma_bs_nxt;
    logic                dma_dr_nxt;
    logic                dma_rr_nxt;
    logic                write_busy_nxt;
    logic                read_busy_nxt;
    logic [STAT_W-1:0]   status_nxt;

    // State, datapath and registered outputs; reset clears everything to 0.
    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            state_q         <= IDLE;
            index_q         <= '0;
            data_q          <= '0;
            rd_data         <= '0;
            cfg_addr_q      <= '0;
            cfg_be_q        <= '0;
            cfg_bs_q        <= '0;
            err_q           <= 1'b0;
            pp_address      <= '0;
            pp_writeEnable  <= 1'b0;
            pp_dataIn       <= '0;
            pp_switch       <= 1'b0;
            dma_address     <= '0;
            dma_byte_enable <= '0;
            dma_burst_size  <= '0;
            dma_data_ready  <= 1'b0;
            dma_readReady   <= 1'b0;
            status          <= '0;
        end else begin
            state_q         <= state_nxt;
            index_q         <= index_nxt;
            data_q          <= data_nxt;
            rd_data         <= rd_data_nxt;
            cfg_addr_q      <= cfg_addr_nxt;
            cfg_be_q        <= cfg_be_nxt;
            cfg_bs_q        <= cfg_bs_nxt;
            err_q           <= err_nxt;
            pp_address      <= pp_address_nxt;
            pp_writeEnable  <= pp_we_nxt;
            pp_dataIn       <= pp_din_nxt;
            pp_switch       <= pp_switch_nxt;
            dma_address     <= dma_addr_nxt;
            dma_byte_enable <= dma_be_nxt;
            dma_burst_size  <= dma_bs_nxt;
            dma_data_ready  <= dma_dr_nxt;
            dma_readReady   <= dma_rr_nxt;
            status          <= status_nxt;
        end
    end

    // Next-state, datapath updates and error tracking; abort overrides all.
    always_comb begin
        state_nxt    = state_q;
        index_nxt    = index_q;
        data_nxt     = data_q;
        rd_data_nxt  = rd_data;
        cfg_addr_nxt = cfg_addr_q;
        cfg_be_nxt   = cfg_be_q;
        cfg_bs_nxt   = cfg_bs_q;
        err_nxt      = err_q;

        if (cmd_abort) begin
            state_nxt = IDLE;
            index_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            if ((cmd_write_start || cmd_read_start) && (state_q != IDLE)) err_nxt = 1'b1;
            if (wr_data_valid && (state_q != W_FILL))                     err_nxt = 1'b1;
            if (rd_word_ack && (state_q != R_HOLD))                       err_nxt = 1'b1;

            case (state_q)
                IDLE: begin
                    if (cmd_write_start || cmd_read_start) begin
                        cfg_addr_nxt = cfg_address;
                        cfg_be_nxt   = cfg_byte_enable;
                        cfg_bs_nxt   = cfg_burst_size;
                        index_nxt    = '0;
                        state_nxt    = cmd_write_start ? W_FILL : R_LAUNCH;
                        if (cmd_write_start && cmd_read_start) err_nxt = 1'b1;
                    end
                end
                W_FILL: begin
                    if (wr_data_valid) begin
                        data_nxt  = wr_data;
                        state_nxt = W_WRITE;
                    end
                end
                W_WRITE: begin
                    if (index_q == cfg_bs_q) begin
                        state_nxt = W_WAIT_SW;
                    end else begin
                        index_nxt = index_q + IDX_W'(1);
                        state_nxt = W_FILL;
                    end
                end
                W_WAIT_SW: if (switch_ready) state_nxt = W_SWITCH;
                W_SWITCH:  state_nxt = W_LAUNCH;
                W_LAUNCH:  state_nxt = IDLE;
                R_LAUNCH:  state_nxt = R_WAIT_SW;
                R_WAIT_SW: if (switch_ready) state_nxt = R_SWITCH;
                R_SWITCH:  state_nxt = R_ASK;
                R_ASK:     state_nxt = R_STORE;
                R_STORE: begin
                    rd_data_nxt = pp_dataOut;
                    state_nxt   = R_HOLD;
                end
                R_HOLD: begin
                    if (rd_word_ack) begin
                        if (index_q == cfg_bs_q) begin
                            state_nxt = IDLE;
                        end else begin
                            index_nxt = index_q + IDX_W'(1);
                            state_nxt = R_ASK;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Moore output decode of the upcoming state, so outputs register in step with it.
    always_comb begin
        pp_address_nxt = '0;
        pp_we_nxt      = 1'b0;
        pp_din_nxt     = '0;
        pp_switch_nxt  = 1'b0;
        dma_addr_nxt   = '0;
        dma_be_nxt     = '0;
        dma_bs_nxt     = '0;
        dma_dr_nxt     = 1'b0;
        dma_rr_nxt     = 1'b0;

        case (state_nxt)
            W_WRITE: begin
                pp_address_nxt = {1'b0, index_nxt};
                pp_we_nxt      = 1'b1;
                pp_din_nxt     = data_nxt;
            end
            R_ASK:    pp_address_nxt = {1'b0, index_nxt};
            W_SWITCH,
            R_SWITCH: pp_switch_nxt = 1'b1;
            W_LAUNCH: begin
                dma_addr_nxt = cfg_addr_nxt;
                dma_be_nxt   = cfg_be_nxt;
                dma_bs_nxt   = cfg_bs_nxt;
                dma_dr_nxt   = 1'b1;
            end
            R_LAUNCH: begin
                dma_addr_nxt = cfg_addr_nxt;
                dma_be_nxt   = cfg_be_nxt;
                dma_bs_nxt   = cfg_bs_nxt;
                dma_rr_nxt   = 1'b1;
            end
            default: ;
        endcase

        write_busy_nxt = (state_nxt == W_FILL)    || (state_nxt == W_WRITE) ||
                         (state_nxt == W_WAIT_SW) || (state_nxt == W_SWITCH) ||
                         (state_nxt == W_LAUNCH);
        read_busy_nxt  = (state_nxt == R_LAUNCH)  || (state_nxt == R_WAIT_SW) ||
                         (state_nxt == R_SWITCH)  || (state_nxt == R_ASK) ||
                         (state_nxt == R_STORE)   || (state_nxt == R_HOLD);
        status_nxt     = {err_nxt, (state_nxt == R_HOLD), read_busy_nxt, write_busy_nxt};
    end

endmodule

// File: tb/tb_jtag_burst_sequencer.sv
// Directed bench for jtag_burst_sequencer: vector table plus multi-cycle sequences.
module tb_jtag_burst_sequencer;

    logic        JTCK;
    logic        JRSTN;
    logic        cmd_write_start, cmd_read_start, cmd_abort;
    logic [31:0] cfg_address;
    logic [3:0]  cfg_byte_enable;
    logic [7:0]  cfg_burst_size;
    logic        wr_data_valid;
    logic [31:0] wr_data;
    logic        rd_word_ack, switch_ready;
    logic [31:0] pp_dataOut;
    logic [8:0]  pp_address;
    logic        pp_writeEnable;
    logic [31:0] pp_dataIn;
    logic        pp_switch;
    logic [31:0] dma_address;
    logic [3:0]  dma_byte_enable;
    logic [7:0]  dma_burst_size;
    logic        dma_data_ready, dma_readReady;
    logic [31:0] rd_data;
    logic [3:0]  status;

    jtag_burst_sequencer dut (
        .JTCK(JTCK), .JRSTN(JRSTN),
        .cmd_write_start(cmd_write_start), .cmd_read_start(cmd_read_start),
        .cmd_abort(cmd_abort), .cfg_address(cfg_address),
        .cfg_byte_enable(cfg_byte_enable), .cfg_burst_size(cfg_burst_size),
        .wr_data_valid(wr_data_valid), .wr_data(wr_data),
        .rd_word_ack(rd_word_ack), .switch_ready(switch_ready),
        .pp_dataOut(pp_dataOut), .pp_address(pp_address),
        .pp_writeEnable(pp_writeEnable), .pp_dataIn(pp_dataIn),
        .pp_switch(pp_switch), .dma_address(dma_address),
        .dma_byte_enable(dma_byte_enable), .dma_burst_size(dma_burst_size),
        .dma_data_ready(dma_data_ready), .dma_readReady(dma_readReady),
        .rd_data(rd_data), .status(status)
    );

    initial JTCK = 1'b0;
    always #5 JTCK = ~JTCK;

    // Buffer read port: one-cycle latency from pp_address.
    logic [31:0] mem [256];
    always @(posedge JTCK) pp_dataOut <= mem[pp_address[7:0]];

    typedef struct {
        logic        wsp, rsp, ab, wdv;
        logic [31:0] wd;
        logic        ack, sr;
        logic [8:0]  e_addr;
        logic        e_we;
        logic [31:0] e_din;
        logic        e_sw, e_dr, e_rr;
        logic [31:0] e_da;
        logic [3:0]  e_be;
        logic [7:0]  e_bs;
        logic [3:0]  e_st;
    } vec_t;

    vec_t vecs [12];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, c_sw = 0, c_dr = 0, c_rr = 0, c_we = 0;
    logic [31:0] l_da;
    logic [3:0]  l_be;
    logic [7:0]  l_bs;

    localparam logic [31:0] A0 = 32'hAAAA_0000;
    localparam logic [31:0] A1 = 32'hAAAA_0001;
    localparam logic [31:0] A2 = 32'hAAAA_0002;
    localparam logic [31:0] B0 = 32'hBBBB_1000;
    localparam logic [31:0] B1 = 32'hBBBB_1001;

    function automatic vec_t mkv(logic wsp, logic rsp, logic ab, logic wdv, logic [31:0] wd,
                                 logic ack, logic sr, logic [8:0] a, logic we, logic [31:0] din,
                                 logic sw, logic dr, logic rr, logic [31:0] da, logic [3:0] be,
                                 logic [7:0] bs, logic [3:0] st);
        vec_t v;
        v.wsp = wsp; v.rsp = rsp; v.ab = ab; v.wdv = wdv; v.wd = wd; v.ack = ack; v.sr = sr;
        v.e_addr = a; v.e_we = we; v.e_din = din; v.e_sw = sw; v.e_dr = dr; v.e_rr = rr;
        v.e_da = da; v.e_be = be; v.e_bs = bs; v.e_st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock, sample just after the edge and tally pulses.
    task automatic tick();
        @(posedge JTCK);
        #1;
        cyc++;
        if (pp_switch)      c_sw++;
        if (pp_writeEnable) c_we++;
        if (dma_readReady)  c_rr++;
        if (dma_data_ready) begin
            c_dr++;
            l_da = dma_address; l_be = dma_byte_enable; l_bs = dma_burst_size;
        end
    endtask

    task automatic clr_pulses();
        cmd_write_start = 1'b0; cmd_read_start = 1'b0; cmd_abort = 1'b0;
        wr_data_valid = 1'b0; rd_word_ack = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pp_address"}, 32'(pp_address), 32'd0);
        chk({name, "_pp_we"},      32'(pp_writeEnable), 32'd0);
        chk({name, "_pp_din"},     pp_dataIn, 32'd0);
        chk({name, "_pp_switch"},  32'(pp_switch), 32'd0);
        chk({name, "_dma_addr"},   dma_address, 32'd0);
        chk({name, "_dma_be"},     32'(dma_byte_enable), 32'd0);
        chk({name, "_dma_bs"},     32'(dma_burst_size), 32'd0);
        chk({name, "_dma_pulses"}, 32'({dma_data_ready, dma_readReady}), 32'd0);
        chk({name, "_rd_data"},    rd_data, 32'd0);
        chk({name, "_status"},     32'(status), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 20 && !status[2]; k++) tick();
        chk({name, "_valid_timeout"}, 32'(status[2]), 32'd1);
    endtask

    task automatic write_word(input logic [31:0] w);
        wr_data_valid = 1'b1; wr_data = w;
        tick();
        wr_data_valid = 1'b0;
        tick();
    endtask

    initial begin
        int t_sw, t_a, sw0, rr0, dr0, we0;

        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = B0;
        mem[1] = B1;

        JRSTN = 1'b0;
        clr_pulses();
        switch_ready = 1'b0;
        wr_data = '0;
        cfg_address = 32'h1000_0000; cfg_byte_enable = 4'hF; cfg_burst_size = 8'd2;
        tick(); tick();
        JRSTN = 1'b1;
        chk_all_zero("reset");

        // 3-word write burst, then simultaneous starts, then abort.
        vecs[0]  = mkv(1,0,0,0,'0,0,0, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[1]  = mkv(0,0,0,1,A0,0,0, 9'd0,1,A0,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[2]  = mkv(0,0,0,0,'0,0,0, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[3]  = mkv(0,0,0,1,A1,0,0, 9'd1,1,A1,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[4]  = mkv(0,0,0,0,'0,0,0, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[5]  = mkv(0,0,0,1,A2,0,0, 9'd2,1,A2,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[6]  = mkv(0,0,0,0,'0,0,1, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[7]  = mkv(0,0,0,0,'0,0,1, 9'd0,0,'0,    1,0,0, '0,4'h0,8'd0, 4'b0001);
        vecs[8]  = mkv(0,0,0,0,'0,0,1, 9'd0,0,'0,    0,1,0, 32'h1000_0000,4'hF,8'd2, 4'b0001);
        vecs[9]  = mkv(0,0,0,0,'0,0,1, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b0000);
        vecs[10] = mkv(1,1,0,0,'0,0,0, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b1001);
        vecs[11] = mkv(0,0,1,0,'0,0,0, 9'd0,0,'0,    0,0,0, '0,4'h0,8'd0, 4'b0000);

        for (int i = 0; i < 12; i++) begin
            cmd_write_start = vecs[i].wsp; cmd_read_start = vecs[i].rsp; cmd_abort = vecs[i].ab;
            wr_data_valid = vecs[i].wdv; wr_data = vecs[i].wd;
            rd_word_ack = vecs[i].ack; switch_ready = vecs[i].sr;
            tick();
            clr_pulses();
            chk($sformatf("v%0d_pp_address", i), 32'(pp_address), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_pp_we", i), 32'(pp_writeEnable), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_pp_din", i), pp_dataIn, vecs[i].e_din);
            chk($sformatf("v%0d_pp_switch", i), 32'(pp_switch), 32'(vecs[i].e_sw));
            chk($sformatf("v%0d_dma_dr", i), 32'(dma_data_ready), 32'(vecs[i].e_dr));
            chk($sformatf("v%0d_dma_rr", i), 32'(dma_readReady), 32'(vecs[i].e_rr));
            chk($sformatf("v%0d_dma_addr", i), dma_address, vecs[i].e_da);
            chk($sformatf("v%0d_dma_be", i), 32'(dma_byte_enable), 32'(vecs[i].e_be));
            chk($sformatf("v%0d_dma_bs", i), 32'(dma_burst_size), 32'(vecs[i].e_bs));
            chk($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].e_st));
        end

        // 2-word read burst with a late switch_ready.
        switch_ready = 1'b0;
        cfg_address = 32'h2000_0040; cfg_byte_enable = 4'h3; cfg_burst_size = 8'd1;
        rr0 = c_rr; sw0 = c_sw;
        cmd_read_start = 1'b1;
        tick();
        clr_pulses();
        chk("rd_launch_pulse", 32'(dma_readReady), 32'd1);
        chk("rd_launch_addr", dma_address, 32'h2000_0040);
        chk("rd_launch_be", 32'(dma_byte_enable), 32'h3);
        chk("rd_launch_bs", 32'(dma_burst_size), 32'd1);
        chk("rd_launch_status", 32'(status), 32'b0010);
        for (int k = 0; k < 10; k++) tick();
        chk("rd_no_early_switch", 32'(c_sw - sw0), 32'd0);
        chk("rd_wait_status", 32'(status), 32'b0010);
        switch_ready = 1'b1;
        tick();
        switch_ready = 1'b0;
        chk("rd_switch_pulse", 32'(pp_switch), 32'd1);
        t_sw = cyc;
        wait_valid("rd_w0");
        chk("rd_w0_latency", 32'(cyc - t_sw), 32'd3);
        chk("rd_w0_data", rd_data, B0);
        tick(); tick();
        chk("rd_w0_hold_status", 32'(status), 32'b0110);
        chk("rd_w0_hold_data", rd_data, B0);
        t_a = cyc;
        rd_word_ack = 1'b1;
        tick();
        clr_pulses();
        wait_valid("rd_w1");
        chk("rd_w1_latency", 32'(cyc - t_a), 32'd3);
        chk("rd_w1_data", rd_data, B1);
        rd_word_ack = 1'b1;
        tick();
        clr_pulses();
        chk("rd_done_status", 32'(status), 32'd0);
        chk("rd_one_launch", 32'(c_rr - rr0), 32'd1);
        chk("rd_one_switch", 32'(c_sw - sw0), 32'd1);

        // Full 256-word write burst.
        switch_ready = 1'b1;
        cfg_address = 32'h3000_0000; cfg_byte_enable = 4'hC; cfg_burst_size = 8'd255;
        we0 = c_we; dr0 = c_dr; sw0 = c_sw;
        cmd_write_start = 1'b1;
        tick();
        clr_pulses();
        for (int i = 0; i < 256; i++) begin
            wr_data_valid = 1'b1; wr_data = 32'h5A5A_0000 ^ 32'(i);
            tick();
            wr_data_valid = 1'b0;
            chk($sformatf("full_addr_%0d", i), 32'(pp_address), 32'(i));
            chk($sformatf("full_din_%0d", i), pp_dataIn, 32'h5A5A_0000 ^ 32'(i));
            tick();
        end
        chk("full_wait_status", 32'(status), 32'b0001);
        tick();
        chk("full_switch", 32'(pp_switch), 32'd1);
        tick();
        chk("full_launch", 32'(dma_data_ready), 32'd1);
        tick();
        chk("full_idle", 32'(status), 32'd0);
        chk("full_write_count", 32'(c_we - we0), 32'd256);
        chk("full_one_launch", 32'(c_dr - dr0), 32'd1);
        chk("full_one_switch", 32'(c_sw - sw0), 32'd1);
        chk("full_launch_bs", 32'(l_bs), 32'd255);
        chk("full_launch_addr", l_da, 32'h3000_0000);
        chk("full_launch_be", 32'(l_be), 32'hC);

        // Stray read start and ack during a write burst.
        cfg_address = 32'h4000_0000; cfg_byte_enable = 4'h5; cfg_burst_size = 8'd1;
        rr0 = c_rr;
        cmd_write_start = 1'b1;
        tick();
        clr_pulses();
        cfg_address = 32'hDEAD_0000; cfg_burst_size = 8'd7;
        cmd_read_start = 1'b1;
        tick();
        clr_pulses();
        chk("err_start_in_fill", 32'(status), 32'b1001);
        rd_word_ack = 1'b1;
        tick();
        clr_pulses();
        chk("err_stray_ack", 32'(status), 32'b1001);
        write_word(32'h1111_0000);
        write_word(32'h1111_0001);
        chk("err_wait_status", 32'(status), 32'b1001);
        tick();
        chk("err_switch", 32'(pp_switch), 32'd1);
        tick();
        chk("err_launch", 32'(dma_data_ready), 32'd1);
        chk("err_launch_addr", dma_address, 32'h4000_0000);
        chk("err_launch_bs", 32'(dma_burst_size), 32'd1);
        chk("err_launch_be", 32'(dma_byte_enable), 32'h5);
        tick();
        chk("err_sticky_idle", 32'(status), 32'b1000);
        chk("err_no_read_launch", 32'(c_rr - rr0), 32'd0);
        cmd_abort = 1'b1;
        tick();
        clr_pulses();
        chk("err_abort_clears", 32'(status), 32'd0);
        wr_data_valid = 1'b1;
        tick();
        clr_pulses();
        chk("err_stray_wdv", 32'(status), 32'b1000);
        cmd_abort = 1'b1;
        tick();
        clr_pulses();
        chk("err_abort_clears2", 32'(status), 32'd0);

        // Reset while holding a read word.
        cfg_address = 32'h5000_0000; cfg_byte_enable = 4'hF; cfg_burst_size = 8'd0;
        switch_ready = 1'b1;
        cmd_read_start = 1'b1;
        tick();
        clr_pulses();
        wait_valid("rst_hold");
        chk("rst_hold_data", rd_data, B0);
        sw0 = c_sw; dr0 = c_dr; rr0 = c_rr;
        JRSTN = 1'b0;
        tick();
        JRSTN = 1'b1;
        chk_all_zero("rst_hold");
        for (int k = 0; k < 5; k++) tick();
        chk("rst_no_pulses", 32'((c_sw - sw0) + (c_dr - dr0) + (c_rr - rr0)), 32'd0);
        chk("rst_status_idle", 32'(status), 32'd0);

        // Abort in W_WAIT_SW.
        switch_ready = 1'b0;
        cmd_write_start = 1'b1;
        tick();
        clr_pulses();
        write_word(32'h2222_0000);
        chk("abort_wait_status", 32'(status), 32'b0001);
        sw0 = c_sw; dr0 = c_dr; rr0 = c_rr;
        cmd_abort = 1'b1; switch_ready = 1'b1;
        tick();
        clr_pulses();
        chk_all_zero("abort_wait");
        for (int k = 0; k < 5; k++) tick();
        chk("abort_no_pulses", 32'((c_sw - sw0) + (c_dr - dr0) + (c_rr - rr0)), 32'd0);
        chk("abort_status_idle", 32'(status), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_burst_sequencer.md
# jtag_burst_sequencer

Controller that sequences JTAG-initiated burst transfers through the ping-pong buffer and the DMA. Sits between the chain1 JTAG register file and the ping-pong buffer/DMA pair, in the JTCK domain. Owns the JTAG-side buffer address counter, the buffer-switch handshake and the DMA launch pulses for both write bursts (host → memory) and read bursts (memory → host).

## Interface
Parameters:
- none; widths are fixed, with a 9-bit buffer address and a maximum burst of 256 words.

Ports:
- JTCK  in  1  sole clock; all logic on rising edge.
- JRSTN  in  1  reset; synchronous, active-low.
- cmd_write_start  in  1  one-cycle pulse; start a write burst.
- cmd_read_start  in  1  one-cycle pulse; start a read burst.
- cmd_abort  in  1  one-cycle pulse; return to IDLE and clear the error flag.
- cfg_address  in  32  DMA base address; latched on an accepted start.
- cfg_byte_enable  in  4  DMA byte enables; latched on an accepted start.
- cfg_burst_size  in  8  burst length minus one (0 = 1 word, 255 = 256 words); latched on an accepted start.
- wr_data_valid  in  1  one-cycle pulse; wr_data holds the next word of a write burst.
- wr_data  in  32  write word.
- rd_word_ack  in  1  one-cycle pulse; host has shifted out rd_data.
- switch_ready  in  1  level from the DMA; buffer may be switched.
- pp_dataOut  in  32  buffer read data; 1-cycle latency after pp_address.
- pp_address  out  9  buffer address; bit 8 is always 0.
- pp_writeEnable  out  1  buffer write strobe.
- pp_dataIn  out  32  buffer write data.
- pp_switch  out  1  one-cycle buffer swap pulse.
- dma_address  out  32  DMA address.
- dma_byte_enable  out  4  DMA byte enables.
- dma_burst_size  out  8  DMA burst length minus one.
- dma_data_ready  out  1  one-cycle write-launch pulse.
- dma_readReady  out  1  one-cycle read-launch pulse.
- rd_data  out  32  captured read word.
- status  out  4  {err, rd_data_valid, read_busy, write_busy}.

## Operation
- States: IDLE, W_FILL, W_WRITE, W_WAIT_SW, W_SWITCH, W_LAUNCH, R_LAUNCH, R_WAIT_SW, R_SWITCH, R_ASK, R_STORE, R_HOLD.
- The FSM is Moore. All pp_*/dma_* outputs decode from the current state and are 0 outside their states.
- IDLE:
  - cmd_write_start latches cfg_*, clears the index, and moves to W_FILL.
  - Otherwise, cmd_read_start latches cfg_*, clears the index, and moves to R_LAUNCH.
  - If both starts arrive together, the write wins and err is set.
- W_FILL: wr_data_valid captures wr_data into the data register and moves to W_WRITE.
- W_WRITE:
  - Drives pp_writeEnable=1, pp_address={1'b0,index}, pp_dataIn=data register.
  - If index==burst_size, go to W_WAIT_SW. Otherwise increment index and go to W_FILL.
- W_WAIT_SW: stay until switch_ready=1, then go to W_SWITCH.
- W_SWITCH: pp_switch=1, then go to W_LAUNCH.
- W_LAUNCH: dma_data_ready=1 with dma_address/dma_byte_enable/dma_burst_size driven from latched cfg, then go to IDLE.
- R_LAUNCH: dma_readReady=1 with the same dma fields, then go to R_WAIT_SW.
- R_WAIT_SW: stay until switch_ready=1, then go to R_SWITCH.
- R_SWITCH: pp_switch=1, then go to R_ASK.
- R_ASK: pp_address={1'b0,index}, then go to R_STORE.
- R_STORE: rd_data<=pp_dataOut, then go to R_HOLD.
- R_HOLD: rd_data_valid=1. On rd_word_ack:
  - if index==burst_size, go to IDLE;
  - otherwise increment index and go to R_ASK.
- write_busy is 1 in any W_* state; read_busy is 1 in any R_* state.
- err is sticky. It is set by:
  - a start pulse outside IDLE (the start is ignored and cfg is unchanged);
  - wr_data_valid outside W_FILL (the word is dropped);
  - rd_word_ack outside R_HOLD (ignored);
  - simultaneous starts in IDLE.
- err is cleared only by cmd_abort or reset.
- cmd_abort, in any state, goes to IDLE next cycle, clears index and err, and emits no pulse. It takes priority over every other input that cycle.
- index is 8 bits and never wraps: the burst_size comparison ends the burst at 255 at the latest.

## Timing
- Reset (JRSTN=0 at a rising edge): state=IDLE; index, data register, rd_data, latched cfg and err are all 0. Every output is 0 from the next cycle.
- Reset mid-burst abandons the burst with no switch or launch pulse.
- Start accepted at edge t: first non-IDLE state is visible after edge t.
- Write: wr_data_valid at edge t → pp_writeEnable high in cycle t+1 only. The next wr_data_valid is accepted from the edge after W_WRITE.
- Write completion: the last W_WRITE is followed by W_WAIT_SW.
  - If switch_ready is already 1, pp_switch is high 2 cycles after the last write and dma_data_ready 3 cycles after it.
  - Back in IDLE 4 cycles after the last write.
- Read:
  - dma_readReady is high the cycle after the start.
  - pp_switch is high the cycle after switch_ready is sampled.
  - First rd_data_valid arrives 3 cycles after pp_switch.
  - Each acked word yields the next rd_data_valid 3 cycles after the ack.
- switch_ready is only sampled in W_WAIT_SW and R_WAIT_SW.

## Test plan
- Write burst of 3 words (cfg_burst_size=2, cfg_address=0x1000_0000, cfg_byte_enable=0xF), words A0/A1/A2, switch_ready=1 → pp writes at addresses 0,1,2 with those data; one pp_switch pulse; one dma_data_ready pulse with 0x1000_0000/0xF/2; status returns to 0.
- Read burst of 2 words, switch_ready held 0 for 10 cycles then 1, buffer returns B0,B1 → dma_readReady pulses once; no pp_switch until switch_ready rises; rd_data=B0 then B1, each with rd_data_valid until acked; IDLE after the second ack.
- Full 256-word write (cfg_burst_size=255) → last write at pp_address 255, index does not wrap, exactly one launch.
- cmd_read_start during W_FILL, plus a stray rd_word_ack → both ignored, err=1, write burst completes normally; cmd_abort then clears err.
- Simultaneous cmd_write_start and cmd_read_start in IDLE → write burst taken, err=1, no dma_readReady.
- JRSTN=0 during R_HOLD, and cmd_abort during W_WAIT_SW → IDLE next cycle, all outputs 0, no pp_switch or DMA pulse.
